wb_write_arbiter: RTL
=====================

// Module: wb_write_arbiter
// PURPOSE
//  Sits directly upstream of the register file and owns its single write port (reg_write/write_reg/write_data).
//  Merges two result sources onto that port:
//   - in-order pipeline writeback, which always has priority;
//   - a variable-latency unit (load/mul-div), buffered in a small FIFO.
//  Holds a scoreboard of destination registers with an outstanding variable-latency result.
//  The hazard unit uses the scoreboard to stall on RAW against pending results.
// PARAMETERS
//  XLEN        32  data width of register values
//  DEPTH       4   FIFO entries for variable-latency results (power of two, >=2)
// PORTS
//  clk            in   1     rising-edge clock
//  rst            in   1     synchronous reset, active-high
//  pipe_wr_en     in   1     pipeline writeback valid this cycle
//  pipe_wr_reg    in   5     pipeline destination register
//  pipe_wr_data   in   XLEN  pipeline result
//  vl_valid       in   1     variable-latency unit offers a result
//  vl_ready       out  1     FIFO can accept (= !full, 0 while rst)
//  vl_reg         in   5     destination of offered result
//  vl_data        in   XLEN  offered result
//  issue_valid    in   1     a variable-latency op issues this cycle
//  issue_reg      in   5     its destination register
//  rs1_addr       in   5     source lookup 1 (from decode)
//  rs2_addr       in   5     source lookup 2 (from decode)
//  rs1_busy       out  1     busy[rs1_addr] (combinational)
//  rs2_busy       out  1     busy[rs2_addr] (combinational)
//  busy_mask      out  32    full scoreboard, bit0 always 0
//  reg_write      out  1     to regfile write enable
//  write_reg      out  5     to regfile write address
//  write_data     out  XLEN  to regfile write data
//  fifo_count     out  log2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - FIFO emptied (fifo_count=0); busy_mask=0.
//   - While rst is high: reg_write=0 and vl_ready=0 regardless of other inputs.
//  Write port selection (combinational; the regfile captures at the next posedge):
//   - pipe_wr_en && pipe_wr_reg!=0: port = pipe source. A FIFO entry present this cycle is not popped.
//   - Otherwise, FIFO non-empty: port = FIFO head, which is popped at the posedge.
//   - Otherwise: reg_write=0; write_reg and write_data are don't-care (drive 0).
//   - A pipe write to x0 counts as no request.
//  FIFO:
//   - Push on vl_valid && vl_ready.
//   - vl_reg==0 is accepted (handshake completes) but not stored.
//   - Strict order; no bypass, so a pushed entry can reach the port at the earliest on the next cycle.
//   - vl_ready = !full, registered-count based. A push and a pop in the same cycle are legal when not full.
//   - When full, no push even if a pop occurs that cycle.
//   - Pointers wrap modulo DEPTH; count never exceeds DEPTH and never underflows.
//  Scoreboard:
//   - Set busy[issue_reg] at the posedge when issue_valid && issue_reg!=0.
//   - Clear busy[r] at the posedge when the FIFO head with destination r is popped.
//   - Set and clear of the same register in the same cycle: set wins, because a newer op owns the register.
//   - A pipe write to a busy register does not alter busy.
//   - Pipeline WAW against a pending result is the hazard unit's responsibility, not this block's.
//  Starvation: sustained pipe writes can hold the FIFO indefinitely.
//   - This is acceptable: the pipeline stalls on a busy RAW, which frees the port.
//  Mid-operation reset discards FIFO contents and all busy bits; there is no partial drain.
// STRUCTURE
//  Shared package (cpu_pkg):
//   - XLEN and REG_ADDR_W=5;
//   - typedef wb_entry_t {logic [4:0] rd; logic [XLEN-1:0] data;}.
//  Sub-module wb_fifo: DEPTH-entry sync FIFO of wb_entry_t with push/pop/full/empty/count.
//  Top level holds the port mux, the 32-bit scoreboard and the lookup muxes.
// TESTING
//  1. After rst: busy_mask=0, fifo_count=0, reg_write=0, vl_ready=0 during rst, 1 after.
//  2. Pipe-only, pipe_wr_en=1, rd=5, data=32'hDEAD_BEEF:
//     reg_write=1, write_reg=5, write_data=DEAD_BEEF in the same cycle.
//  3. issue rd=7, later vl push rd=7/data=0x1234 with no pipe traffic:
//     rs1_busy=1 for rs1_addr=7 until the drain cycle; the next cycle emits write_reg=7, data=0x1234; busy[7] clears.
//  4. Push 4 results while pipe_wr_en=1 every cycle (rd!=0):
//     vl_ready drops after the 4th push and no pops occur.
//     Drop pipe_wr_en: drains in push order over 4 cycles; vl_ready returns after the 1st pop.
//  5. Issue rd=9 in the same cycle the FIFO head rd=9 pops: busy[9] remains 1.
//  6. vl push with rd=0: handshake completes, fifo_count unchanged, no write emitted.
//     Also pipe_wr_reg=0 with a non-empty FIFO: the FIFO drains.
//  7. Reset asserted with 3 entries queued and busy bits set: next cycle count=0, mask=0, and no stale writes.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared register-file widths and the writeback entry type.
// Revision : 1.0
// ============================================================================
package cpu_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Brief    : DEPTH-entry synchronous FIFO of writeback entries, strict order.
// Revision : 1.0
// ============================================================================
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    wb_entry_t            r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_entry;
    end
endmodule
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_arbiter
// Brief    : Owns the regfile write port; pipeline writeback beats queued
//            variable-latency results. Tracks pending destinations.
// Revision : 1.0
// ============================================================================
module wb_write_arbiter
    import cpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pipe_wr_en,
    input  logic [4:0]             pipe_wr_reg,
    input  logic [XLEN-1:0]        pipe_wr_data,
    input  logic                   vl_valid,
    output logic                   vl_ready,
    input  logic [4:0]             vl_reg,
    input  logic [XLEN-1:0]        vl_data,
    input  logic                   issue_valid,
    input  logic [4:0]             issue_reg,
    input  logic [4:0]             rs1_addr,
    input  logic [4:0]             rs2_addr,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic [31:0]            busy_mask,
    output logic                   reg_write,
    output logic [4:0]             write_reg,
    output logic [XLEN-1:0]        write_data,
    output logic [$clog2(DEPTH):0] fifo_count
);
    wb_entry_t   w_head;
    wb_entry_t   w_push_entry;
    logic        w_full;
    logic        w_empty;
    logic        w_pipe_req;
    logic        w_pop;
    logic        w_push;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;
    logic [31:0] r_busy;

    assign w_pipe_req   = pipe_wr_en && (pipe_wr_reg != 5'd0);
    assign w_pop        = !rst && !w_pipe_req && !w_empty;
    assign vl_ready     = !rst && !w_full;
    // x0 results complete the handshake but are never stored.
    assign w_push       = vl_valid && vl_ready && (vl_reg != 5'd0);
    assign w_push_entry = '{rd: vl_reg, data: vl_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .head       (w_head),
        .full       (w_full),
        .empty      (w_empty),
        .count      (fifo_count)
    );

    always_comb begin
        reg_write  = 1'b0;
        write_reg  = 5'd0;
        write_data = '0;
        if (!rst) begin
            if (w_pipe_req) begin
                reg_write  = 1'b1;
                write_reg  = pipe_wr_reg;
                write_data = pipe_wr_data;
            end else if (!w_empty) begin
                reg_write  = 1'b1;
                write_reg  = w_head.rd;
                write_data = w_head.data;
            end
        end
    end

    assign w_set_mask = (issue_valid && (issue_reg != 5'd0)) ? (32'd1 << issue_reg) : 32'd0;
    assign w_clr_mask = w_pop ? (32'd1 << w_head.rd) : 32'd0;

    // Set is applied after clear: a newly issued op owns the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 32'd0;
        end else begin
            r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & 32'hFFFF_FFFE;
        end
    end

    assign busy_mask = r_busy;
    assign rs1_busy  = r_busy[rs1_addr];
    assign rs2_busy  = r_busy[rs2_addr];
endmodule
`default_nettype wire
